// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// Optional even-parity bit is enabled with UART_TX_ARB_PARITY_EN.
package uart_tx_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 (or 8E1 with UART_TX_ARB_PARITY_EN) serializer with baud divider.
// Loads a byte in IDLE and shifts it out LSB first on a registered line.
module uart_tx_serializer
   import uart_tx_arb_pkg::*;
#(
   parameter int BAUD_DIV = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [UART_DATA_BITS-1:0] din,
   output logic                      idle,
   output logic                      tx
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(BAUD_DIV - 1);

   uart_state_e               r_state;
   logic [CW-1:0]             r_cnt;
   logic [2:0]                r_bit;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic                      r_tx;
`ifdef UART_TX_ARB_PARITY_EN
   logic                      r_par;
`endif
   logic                      w_tick;

   assign w_tick = (r_cnt == '0);
   assign idle   = (r_state == ST_IDLE);
   assign tx     = r_tx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= UART_IDLE_LEVEL;
`ifdef UART_TX_ARB_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_state <= ST_START;
                  r_tx    <= 1'b0;
                  r_cnt   <= CNT_LOAD;
                  r_bit   <= '0;
                  r_shift <= din;
`ifdef UART_TX_ARB_PARITY_EN
                  r_par   <= ^din;
`endif
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_state <= ST_DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_cnt   <= CNT_LOAD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  // bit counter wraps 7->0 on the way out
                  r_bit <= r_bit + 3'd1;
                  r_cnt <= CNT_LOAD;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                     r_state <= ST_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= ST_STOP;
                     r_tx    <= UART_IDLE_LEVEL;
`endif
                  end else begin
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_state <= ST_STOP;
                  r_tx    <= UART_IDLE_LEVEL;
                  r_cnt   <= CNT_LOAD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NUM_REQ producers.
// Parity frames are built when UART_TX_ARB_PARITY_EN is defined.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   parameter  int BAUD_DIV = 256,
   localparam int GW       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [8*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  uart_tx,
   output logic                  busy,
   output logic [GW-1:0]         grant_id
);

   logic [GW-1:0]             r_last_grant;
   logic [GW-1:0]             r_grant_id;
   logic [GW-1:0]             w_pick;
   logic [GW-1:0]             w_cand;
   logic                      w_found;
   logic                      w_idle;
   logic                      w_load;
   logic [UART_DATA_BITS-1:0] w_din;

   // search starts just after the last winner and wraps
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      w_din = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick == GW'(i)) begin
            w_din = req_data[8*i +: 8];
         end
      end
   end

   assign w_load    = w_idle & w_found & ~reset;
   assign req_ready = w_load ? (NUM_REQ'(1) << w_pick) : '0;
   assign busy      = ~w_idle;
   assign grant_id  = r_grant_id;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= GW'(NUM_REQ - 1);
         r_grant_id   <= '0;
      end else if (w_load) begin
         r_last_grant <= w_pick;
         r_grant_id   <= w_pick;
      end
   end

   uart_tx_serializer #(
      .BAUD_DIV (BAUD_DIV)
   ) u_ser (
      .clk   (clk),
      .reset (reset),
      .load  (w_load),
      .din   (w_din),
      .idle  (w_idle),
      .tx    (uart_tx)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter against a frame-level model.
// Define UART_TX_ARB_PARITY_EN to check the parity build as well.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int B  = 4;
`ifdef UART_TX_ARB_PARITY_EN
   localparam int FRAME = 11 * B;
`else
   localparam int FRAME = 10 * B;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            uart_tx;
   logic            busy;
   logic [1:0]      grant_id;
   logic [7:0]      d [NR];

   int n_checks = 0;
   int n_fail   = 0;
   int m_last   = NR - 1;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < NR; i++) req_data[8*i +: 8] = d[2'(i)];
   end

   uart_tx_arbiter #(
      .NUM_REQ  (NR),
      .BAUD_DIV (B)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   // expected line level j cycles after the handshake cycle
   function automatic logic exp_tx(int j, logic [7:0] b);
      if (j <= B) return 1'b0;
      if (j <= 9 * B) return b[3'((j - 1) / B - 1)];
`ifdef UART_TX_ARB_PARITY_EN
      if (j <= 10 * B) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic int model_pick(logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         int idx;
         idx = (m_last + k) % NR;
         if (v[2'(idx)]) return idx;
      end
      return -1;
   endfunction

   task automatic wait_hs(output bit ok, output int hs_cyc);
      int n;
      n = 0;
      #1;
      while (req_ready === '0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = (req_ready !== '0);
      hs_cyc = cyc;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_timeout: no req_ready within 200 cycles");
      end
   endtask

   task automatic run_frame(input int g, input bit drop,
                            input logic [NR-1:0] raise, output int hs_cyc);
      bit         ok;
      logic [7:0] b;
      logic [7:0] got;
      logic [NR-1:0] exp_rdy;
      wait_hs(ok, hs_cyc);
      if (!ok) return;
      b = d[2'(g)];
      exp_rdy = NR'(1) << g;
      n_checks++;
      if (req_ready !== exp_rdy) begin
         n_fail++;
         $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
      end
      n_checks++;
      if (busy !== 1'b0 || uart_tx !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_at_hs: busy=%b tx=%b want 0/1", busy, uart_tx);
      end
      m_last = g;
      got = '0;
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         #1;
         if (j == 1 && drop) req_valid[2'(g)] = 1'b0;
         if (j == 5 * B) begin
            for (int i = 0; i < NR; i++) begin
               if (raise[2'(i)] && !req_valid[2'(i)]) begin
                  d[2'(i)] = 8'($urandom);
                  req_valid[2'(i)] = 1'b1;
               end
            end
         end
         n_checks++;
         if (uart_tx !== exp_tx(j, b)) begin
            n_fail++;
            $display("FAIL tx j=%0d: got %b want %b", j, uart_tx, exp_tx(j, b));
         end
         n_checks++;
         if (busy !== 1'b1 || req_ready !== '0 || grant_id !== 2'(g)) begin
            n_fail++;
            $display("FAIL status j=%0d: busy=%b rdy=%b gid=%0d want 1/0/%0d",
                     j, busy, req_ready, grant_id, g);
         end
         if (j > B && j <= 9 * B && ((j - 1) % B) == B / 2)
            got[3'((j - 1) / B - 1)] = uart_tx;
      end
      n_checks++;
      if (got !== b) begin
         n_fail++;
         $display("FAIL byte: got %h want %h", got, b);
      end
   endtask

   task automatic test_reset();
      int hs;
      reset = 1'b1;
      req_valid = '1;
      for (int i = 0; i < NR; i++) d[2'(i)] = 8'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (uart_tx !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_tx: got %b want 1", uart_tx);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_busy: got %b want 0", busy);
      end
      n_checks++;
      if (req_ready !== '0) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 0", req_ready);
      end
      n_checks++;
      if (grant_id !== 2'd0) begin
         n_fail++;
         $display("FAIL rst_gid: got %0d want 0", grant_id);
      end
      reset = 1'b0;
      m_last = NR - 1;
      run_frame(0, 1'b1, '0, hs);
      req_valid = '0;
   endtask

   task automatic test_single_frame();
      int hs;
      d[1] = 8'hA5;
      req_valid = 4'b0010;
      run_frame(1, 1'b1, '0, hs);
   endtask

   task automatic test_fairness();
      int hs;
      int prev;
      reset = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;
      m_last = NR - 1;
      prev = 0;
      for (int i = 0; i < NR; i++) d[2'(i)] = 8'(8'h10 + i);
      req_valid = '1;
      for (int r = 0; r < 5; r++) begin
         run_frame(r % NR, 1'b0, '0, hs);
         if (r > 0) begin
            n_checks++;
            if (hs - prev !== FRAME + 1) begin
               n_fail++;
               $display("FAIL hs_gap: got %0d want %0d", hs - prev, FRAME + 1);
            end
         end
         prev = hs;
      end
      req_valid = '0;
   endtask

   task automatic test_wrap();
      int hs;
      d[3] = 8'($urandom);
      req_valid = 4'b1000;
      run_frame(model_pick(req_valid), 1'b1, '0, hs);
      d[0] = 8'($urandom);
      d[2] = 8'($urandom);
      req_valid = 4'b0101;
      run_frame(model_pick(req_valid), 1'b1, '0, hs);
      run_frame(model_pick(req_valid), 1'b1, '0, hs);
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int hs;
      d[1] = 8'($urandom);
      req_valid = 4'b0010;
      wait_hs(ok, hs);
      if (ok) begin
         repeat (4 * B + 2) begin
            @(negedge clk);
            #1;
         end
         d[0] = 8'($urandom);
         req_valid[0] = 1'b1;
         reset = 1'b1;
         @(negedge clk);
         #1;
         n_checks++;
         if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_line: tx=%b busy=%b want 1/0", uart_tx, busy);
         end
         n_checks++;
         if (req_ready !== '0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_arb: rdy=%b gid=%0d want 0/0", req_ready, grant_id);
         end
         reset = 1'b0;
         m_last = NR - 1;
         run_frame(model_pick(req_valid), 1'b1, '0, hs);
         run_frame(model_pick(req_valid), 1'b1, '0, hs);
      end
      req_valid = '0;
   endtask

   task automatic test_random();
      int hs;
      logic [NR-1:0] mask;
      logic [NR-1:0] fresh;
      for (int r = 0; r < 20; r++) begin
         mask  = NR'($urandom_range(0, 15));
         fresh = mask & ~req_valid;
         for (int i = 0; i < NR; i++)
            if (fresh[2'(i)]) d[2'(i)] = 8'($urandom);
         req_valid = mask;
         if (mask == '0) begin
            repeat (3) begin
               @(negedge clk);
               #1;
               n_checks++;
               if (uart_tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0) begin
                  n_fail++;
                  $display("FAIL no_req: tx=%b busy=%b rdy=%b want 1/0/0",
                           uart_tx, busy, req_ready);
               end
            end
         end else begin
            run_frame(model_pick(mask), 1'b1, NR'($urandom), hs);
         end
      end
      req_valid = '0;
   endtask

`ifdef UART_TX_ARB_PARITY_EN
   task automatic test_parity();
      int hs;
      d[0] = 8'h07;
      req_valid = 4'b0001;
      m_last = NR - 1;
      reset = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;
      run_frame(0, 1'b1, '0, hs);
      req_valid = '0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NR; i++) d[2'(i)] = '0;
      test_reset();
      test_single_frame();
      test_fairness();
      test_wrap();
      test_reset_midframe();
      test_random();
`ifdef UART_TX_ARB_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
